// File: rtl/pipe_hazard_pkg.sv
// Shared stage indices, per-stage metadata type and width helper for the pipeline hazard controller.
// PIPE_FWD_EN selects operand forwarding; when it is undefined every producer stalls D until it retires.
package pipe_hazard_pkg;

    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_X = 2;

    // Wide enough for any register-file address width used by the core.
    localparam int RD_W_MAX = 8;

`ifdef PIPE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [RD_W_MAX-1:0] rd;
        logic                rd_wen;
        logic                is_load;
    } stage_meta_t;

    function automatic int sel_width(input int stages);
        return $clog2(stages - 1);
    endfunction

endpackage

// File: rtl/pipe_src_match.sv
// Per-operand producer search across stages X..W: youngest matching stage select and stall flag.
// Behaviour depends on PIPE_FWD_EN (through pipe_hazard_pkg::FWD_EN).
module pipe_src_match
    import pipe_hazard_pkg::*;
#(
    parameter int STAGES     = 5,
    parameter int REG_AW     = 5,
    parameter int LOAD_STAGE = 3,
    parameter int SEL_W      = 2
) (
    input  logic [REG_AW-1:0]             rs,
    input  logic                          used,
    input  logic [STAGES-1:STG_X]         valid,
    input  stage_meta_t [STAGES-1:STG_X]  meta,
    output logic [SEL_W-1:0]              sel,
    output logic                          hazard
);

    // Without forwarding, every producer acts like a load whose data is never forwardable.
    localparam int HZ_LIMIT = FWD_EN ? LOAD_STAGE : STAGES;

    logic [RD_W_MAX-1:0] rs_ext;

    assign rs_ext = RD_W_MAX'(rs);

    // Walk from oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        sel    = '0;
        hazard = 1'b0;
        for (int s = STAGES - 1; s >= STG_X; s--) begin
            if (used && valid[s] && meta[s].rd_wen &&
                (meta[s].rd != '0) && (meta[s].rd == rs_ext)) begin
                sel    = FWD_EN ? SEL_W'(s - 1) : '0;
                hazard = (meta[s].is_load || !FWD_EN) && (s < HZ_LIMIT);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// N-stage pipeline valid/kill/stall control with decode-stage operand bypass selects.
// Forwarding is enabled by defining PIPE_FWD_EN; otherwise D stalls until the producer leaves W.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int STAGES     = 5,
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 5,
    parameter int LOAD_STAGE = 3,
    parameter int SEL_W      = sel_width(STAGES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       f_valid_in,
    input  logic [NUM_SRC*REG_AW-1:0]  d_rs,
    input  logic [NUM_SRC-1:0]         d_rs_used,
    input  logic [REG_AW-1:0]          d_rd,
    input  logic                       d_rd_wen,
    input  logic                       d_is_load,
    input  logic [STAGES-1:0]          redir_req,
    input  logic                       ext_stall,
    output logic [STAGES-1:0]          stage_valid,
    output logic                       stall_fd,
    output logic                       bubble_x,
    output logic [NUM_SRC*SEL_W-1:0]   byp_sel,
    output logic [STAGES-1:0]          redir_sel
);

    logic [STAGES-1:0]             valid_q;
    logic [STAGES-1:0]             valid_d;
    stage_meta_t [STAGES-1:STG_X]  meta_q;
    stage_meta_t [STAGES-1:STG_X]  meta_d;
    stage_meta_t                   d_meta;
    logic [NUM_SRC-1:0]            src_hz;
    logic                          hz_raw;
    logic                          hz_stall;
    logic [STAGES-1:STG_D]         acc;
    logic [STAGES-2:0]             kill;
    logic                          unused_redir_f;

    // Fetch never redirects itself.
    assign unused_redir_f = redir_req[STG_F];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        pipe_src_match #(
            .STAGES     (STAGES),
            .REG_AW     (REG_AW),
            .LOAD_STAGE (LOAD_STAGE),
            .SEL_W      (SEL_W)
        ) u_match (
            .rs     (d_rs[gi*REG_AW +: REG_AW]),
            .used   (d_rs_used[gi]),
            .valid  (valid_q[STAGES-1:STG_X]),
            .meta   (meta_q),
            .sel    (byp_sel[gi*SEL_W +: SEL_W]),
            .hazard (src_hz[gi])
        );
    end

    assign hz_raw = valid_q[STG_D] & (|src_hz);
    assign d_meta = {RD_W_MAX'(d_rd), d_rd_wen, d_is_load};

    always_comb begin
        acc       = '0;
        redir_sel = '0;
        kill      = '0;
        for (int k = STG_D; k < STAGES; k++) begin
            acc[k] = redir_req[k] & valid_q[k] & ~ext_stall;
        end
        acc[STG_D] = acc[STG_D] & ~hz_raw;
        for (int k = STG_D; k < STAGES; k++) begin
            if (acc[k]) begin
                redir_sel    = '0;
                redir_sel[k] = 1'b1;
            end
        end
        kill[STAGES-2] = acc[STAGES-1];
        for (int j = STAGES - 3; j >= 0; j--) begin
            kill[j] = kill[j+1] | acc[j+1];
        end
    end

    // A redirect from X or older squashes D, so its stall no longer matters.
    assign hz_stall = hz_raw & ~kill[STG_D];

    assign stage_valid = valid_q;
    assign stall_fd    = (hz_stall | ext_stall) & ~rst;
    assign bubble_x    = hz_stall & ~ext_stall;

    always_comb begin
        valid_d = valid_q;
        meta_d  = meta_q;
        if (!ext_stall) begin
            if (hz_stall) begin
                valid_d[STG_X] = 1'b0;
                meta_d[STG_X]  = '0;
            end else begin
                valid_d[STG_F] = f_valid_in;
                valid_d[STG_D] = valid_q[STG_F] & ~kill[STG_F];
                valid_d[STG_X] = valid_q[STG_D] & ~kill[STG_D];
                meta_d[STG_X]  = d_meta;
            end
            for (int j = STG_X; j < STAGES - 1; j++) begin
                valid_d[j+1] = valid_q[j] & ~kill[j];
                meta_d[j+1]  = meta_q[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            meta_q  <= '0;
        end else begin
            valid_q <= valid_d;
            meta_q  <= meta_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (default 5-stage, 2-operand build).
// Expectations for the load-use sequence depend on PIPE_FWD_EN.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] v;
        logic       st;
        logic       bb;
        logic [3:0] byp;
        logic [4:0] rsel;
    } exp_t;

`ifdef PIPE_FWD_EN
    localparam logic [3:0] PRE_STALL_BYP = 4'h1;
`else
    localparam logic [3:0] PRE_STALL_BYP = 4'h0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       f_valid_in;
    logic [9:0] d_rs;
    logic [1:0] d_rs_used;
    logic [4:0] d_rd;
    logic       d_rd_wen;
    logic       d_is_load;
    logic [4:0] redir_req;
    logic       ext_stall;
    logic [4:0] stage_valid;
    logic       stall_fd;
    logic       bubble_x;
    logic [3:0] byp_sel;
    logic [4:0] redir_sel;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    pipe_hazard_ctrl #(
        .STAGES     (5),
        .NUM_SRC    (2),
        .REG_AW     (5),
        .LOAD_STAGE (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .f_valid_in  (f_valid_in),
        .d_rs        (d_rs),
        .d_rs_used   (d_rs_used),
        .d_rd        (d_rd),
        .d_rd_wen    (d_rd_wen),
        .d_is_load   (d_is_load),
        .redir_req   (redir_req),
        .ext_stall   (ext_stall),
        .stage_valid (stage_valid),
        .stall_fd    (stall_fd),
        .bubble_x    (bubble_x),
        .byp_sel     (byp_sel),
        .redir_sel   (redir_sel)
    );

    always #5 clk = ~clk;

    task automatic check_field(input string nm, input string fld,
                               input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s got=%0h expected=%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so each cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check_field(nm, "stage_valid", 32'(stage_valid), 32'(e.v));
            check_field(nm, "stall_fd",    32'(stall_fd),    32'(e.st));
            check_field(nm, "bubble_x",    32'(bubble_x),    32'(e.bb));
            check_field(nm, "byp_sel",     32'(byp_sel),     32'(e.byp));
            check_field(nm, "redir_sel",   32'(redir_sel),   32'(e.rsel));
        end
    end

    task automatic set_d(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                         input logic [4:0] rd, input logic wen, input logic ld);
        d_rs      = {rs1, rs0};
        d_rs_used = used;
        d_rd      = rd;
        d_rd_wen  = wen;
        d_is_load = ld;
    endtask

    task automatic nop_d();
        set_d(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    // Called just after a rising edge; expectations describe outputs during this cycle.
    task automatic step(input string nm, input logic fv, input logic [4:0] rq, input logic es,
                        input logic [4:0] ev, input logic est, input logic ebb,
                        input logic [3:0] eby, input logic [4:0] ers);
        f_valid_in = fv;
        redir_req  = rq;
        ext_stall  = es;
        exp_q.push_back({ev, est, ebb, eby, ers});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        nop_d();
        step("reset", 1'b0, 5'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 4'h0, 5'b0);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        f_valid_in = 1'b0;
        redir_req  = '0;
        ext_stall  = 1'b0;
        nop_d();
        @(posedge clk);
        #1;

        // Reset with hostile inputs: every output must stay at zero.
        set_d(5'd6, 5'd6, 2'b11, 5'd6, 1'b1, 1'b1);
        step("reset_init", 1'b1, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0, 4'h0, 5'b0);

        // Load-use / forwarding sequence.
        reset_pulse();
        nop_d();
        step("ld_c0", 1'b1, 5'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 4'h0, 5'b0);
        step("ld_c1", 1'b1, 5'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 4'h0, 5'b0);
`ifdef PIPE_FWD_EN
        set_d(5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
        step("add_x5", 1'b1, 5'b0, 1'b0, 5'b00011, 1'b0, 1'b0, 4'h0, 5'b0);
        set_d(5'd5, 5'd3, 2'b11, 5'd7, 1'b1, 1'b0);
        step("alu_fwd", 1'b1, 5'b0, 1'b0, 5'b00111, 1'b0, 1'b0, 4'h1, 5'b0);
        set_d(5'd5, 5'd7, 2'b01, 5'd6, 1'b1, 1'b1);
        step("lw_base_fwd", 1'b1, 5'b0, 1'b0, 5'b01111, 1'b0, 1'b0, 4'h2, 5'b0);
        set_d(5'd6, 5'd5, 2'b11, 5'd8, 1'b1, 1'b0);
        step("load_use_stall", 1'b1, 5'b0, 1'b0, 5'b11111, 1'b1, 1'b1, 4'hD, 5'b0);
        step("load_use_fwd", 1'b1, 5'b0, 1'b0, 5'b11011, 1'b0, 1'b0, 4'h2, 5'b0);
        nop_d();
        step("after_fwd", 1'b1, 5'b0, 1'b0, 5'b10111, 1'b0, 1'b0, 4'h0, 5'b0);
`else
        set_d(5'd1, 5'd0, 2'b01, 5'd6, 1'b1, 1'b1);
        step("lw_x6", 1'b1, 5'b0, 1'b0, 5'b00011, 1'b0, 1'b0, 4'h0, 5'b0);
        set_d(5'd6, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0);
        step("nofwd_stall1", 1'b1, 5'b0, 1'b0, 5'b00111, 1'b1, 1'b1, 4'h0, 5'b0);
        step("nofwd_stall2", 1'b1, 5'b0, 1'b0, 5'b01011, 1'b1, 1'b1, 4'h0, 5'b0);
        step("nofwd_stall3", 1'b1, 5'b0, 1'b0, 5'b10011, 1'b1, 1'b1, 4'h0, 5'b0);
        step("nofwd_go", 1'b1, 5'b0, 1'b0, 5'b00011, 1'b0, 1'b0, 4'h0, 5'b0);
        nop_d();
        step("nofwd_after", 1'b1, 5'b0, 1'b0, 5'b00111, 1'b0, 1'b0, 4'h0, 5'b0);
`endif

        // Redirect arbitration and kills.
        reset_pulse();
        nop_d();
        step("fill0", 1'b1, 5'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 4'h0, 5'b0);
        step("fill1", 1'b1, 5'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 4'h0, 5'b0);
        step("fill2", 1'b1, 5'b0, 1'b0, 5'b00011, 1'b0, 1'b0, 4'h0, 5'b0);
        step("fill3", 1'b1, 5'b0, 1'b0, 5'b00111, 1'b0, 1'b0, 4'h0, 5'b0);
        step("fill4", 1'b1, 5'b0, 1'b0, 5'b01111, 1'b0, 1'b0, 4'h0, 5'b0);
        step("redir_xd", 1'b1, 5'b00110, 1'b0, 5'b11111, 1'b0, 1'b0, 4'h0, 5'b00100);
        step("redir_kill", 1'b1, 5'b00000, 1'b0, 5'b11001, 1'b0, 1'b0, 4'h0, 5'b0);
        step("redir_d", 1'b1, 5'b00010, 1'b0, 5'b10011, 1'b0, 1'b0, 4'h0, 5'b00010);
        step("redir_invalid", 1'b1, 5'b11000, 1'b0, 5'b00101, 1'b0, 1'b0, 4'h0, 5'b0);
        step("redir_oldest", 1'b1, 5'b01010, 1'b0, 5'b01011, 1'b0, 1'b0, 4'h0, 5'b01000);
        step("redir_old_kill", 1'b1, 5'b00000, 1'b0, 5'b10001, 1'b0, 1'b0, 4'h0, 5'b0);

        // Writes to x0 never forward or stall; then ext_stall with a pending redirect.
        reset_pulse();
        nop_d();
        step("x0_c0", 1'b1, 5'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 4'h0, 5'b0);
        step("x0_c1", 1'b1, 5'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 4'h0, 5'b0);
        set_d(5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b0);
        step("add_x0", 1'b1, 5'b0, 1'b0, 5'b00011, 1'b0, 1'b0, 4'h0, 5'b0);
        set_d(5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1);
        step("lw_x0", 1'b1, 5'b0, 1'b0, 5'b00111, 1'b0, 1'b0, 4'h0, 5'b0);
        set_d(5'd0, 5'd0, 2'b11, 5'd9, 1'b1, 1'b0);
        step("x0_read", 1'b1, 5'b0, 1'b0, 5'b01111, 1'b0, 1'b0, 4'h0, 5'b0);
        nop_d();
        step("ext1", 1'b1, 5'b00100, 1'b1, 5'b11111, 1'b1, 1'b0, 4'h0, 5'b0);
        step("ext2", 1'b1, 5'b00100, 1'b1, 5'b11111, 1'b1, 1'b0, 4'h0, 5'b0);
        step("ext3", 1'b1, 5'b00100, 1'b1, 5'b11111, 1'b1, 1'b0, 4'h0, 5'b0);
        step("ext_release", 1'b1, 5'b00100, 1'b0, 5'b11111, 1'b0, 1'b0, 4'h0, 5'b00100);
        step("ext_after", 1'b1, 5'b00000, 1'b0, 5'b11001, 1'b0, 1'b0, 4'h0, 5'b0);

        // Reset asserted in the middle of a load-use stall.
        reset_pulse();
        nop_d();
        step("rs_c0", 1'b1, 5'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 4'h0, 5'b0);
        step("rs_c1", 1'b1, 5'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 4'h0, 5'b0);
        set_d(5'd1, 5'd0, 2'b01, 5'd6, 1'b1, 1'b1);
        step("rs_lw", 1'b1, 5'b0, 1'b0, 5'b00011, 1'b0, 1'b0, 4'h0, 5'b0);
        set_d(5'd6, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
        step("rst_pre_stall", 1'b1, 5'b0, 1'b0, 5'b00111, 1'b1, 1'b1, PRE_STALL_BYP, 5'b0);
        rst = 1'b1;
        step("rst_mid", 1'b1, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0, 4'h0, 5'b0);
        step("rst_hold", 1'b1, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0, 4'h0, 5'b0);
        rst = 1'b0;
        nop_d();
        step("rst_release", 1'b0, 5'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 4'h0, 5'b0);
        step("rst_no_spurious", 1'b1, 5'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 4'h0, 5'b0);
        step("rst_first_fetch", 1'b0, 5'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 4'h0, 5'b0);

        repeat (2) @(posedge clk);
        #1;
        check_field("drain", "pending", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
